// File: rtl/ga_mutation_algo.sv
// ga_mutation_algo
// -----------------------------------------------------------------------------
// Mutation stage of a genetic-algorithm pipeline. The block accepts one
// crossover child at a time, walks its active elements one per cycle, and
// flips a single random bit in each element whose random draw falls below
// the mutation rate. The mutated chromosome is then presented downstream
// until it is acknowledged.
//
// Ports
//   clk           rising-edge clock
//   rstn          synchronous active-low reset
//   sw_rst        synchronous active-high soft reset (same effect as rstn)
//   cnfg_m        active element count (values above M_MAX are clamped)
//   cnfg_mut_rate per-element mutation threshold
//   rand_data     random word: [RATE_W-1:0] draw, [RAND_W-1:RATE_W] bit select
//   child_valid   crossover child available
//   child_ary     crossover child, M_MAX elements of DATA_W bits
//   child_ack     child accepted this cycle (combinational, IDLE only)
//   mutant_valid  mutated chromosome available
//   mutant_ary    mutated chromosome
//   mutant_ack    downstream accepts the mutant
//   mut_cnt       number of bit flips applied to the current mutant (saturating)
// -----------------------------------------------------------------------------
module ga_mutation_algo #(
    parameter int DATA_W     = 16,
    parameter int DATA_IDX_W = 4,
    parameter int M_MAX      = 32,
    parameter int M_MAX_W    = 6,
    parameter int RATE_W     = 8,
    localparam int RAND_W    = RATE_W + DATA_IDX_W
) (
    input  logic                          clk,
    input  logic                          rstn,
    input  logic                          sw_rst,
    input  logic [M_MAX_W-1:0]            cnfg_m,
    input  logic [RATE_W-1:0]             cnfg_mut_rate,
    input  logic [RAND_W-1:0]             rand_data,
    input  logic                          child_valid,
    input  logic [M_MAX-1:0][DATA_W-1:0]  child_ary,
    output logic                          child_ack,
    output logic                          mutant_valid,
    output logic [M_MAX-1:0][DATA_W-1:0]  mutant_ary,
    input  logic                          mutant_ack,
    output logic [M_MAX_W-1:0]            mut_cnt
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        MUTATE = 2'd1,
        OUT    = 2'd2
    } state_e;

    state_e                        state_q, state_d;
    logic [M_MAX-1:0][DATA_W-1:0]  buf_q, buf_d;
    logic [M_MAX_W-1:0]            m_q, m_d;
    logic [RATE_W-1:0]             rate_q, rate_d;
    logic [M_MAX_W-1:0]            idx_q, idx_d;
    logic [M_MAX_W-1:0]            cnt_q, cnt_d;
    logic                          valid_q, valid_d;

    logic                          rst_any;
    logic [M_MAX_W-1:0]            m_clamp;
    logic                          do_flip;
    logic [DATA_W-1:0]             flip_mask;

    assign rst_any = !rstn || sw_rst;

    // Child handshake is only offered while idle and out of reset, so a child
    // presented during MUTATE/OUT simply waits upstream.
    assign child_ack = (state_q == IDLE) && !rst_any;

    assign m_clamp   = (cnfg_m > M_MAX_W'(M_MAX)) ? M_MAX_W'(M_MAX) : cnfg_m;
    assign do_flip   = rand_data[RATE_W-1:0] < rate_q;
    assign flip_mask = DATA_W'(1) << rand_data[RAND_W-1:RATE_W];

    always_comb begin
        // NOTE: every next-state variable gets its hold value first; a path
        // that skips an assignment would otherwise infer a latch.
        state_d = state_q;
        buf_d   = buf_q;
        m_d     = m_q;
        rate_d  = rate_q;
        idx_d   = idx_q;
        cnt_d   = cnt_q;
        valid_d = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (child_valid) begin
                    buf_d   = child_ary;
                    m_d     = m_clamp;
                    rate_d  = cnfg_mut_rate;
                    idx_d   = '0;
                    cnt_d   = '0;
                    state_d = (m_clamp == '0) ? OUT : MUTATE;
                end
            end

            MUTATE: begin
                if (do_flip) begin
                    for (int e = 0; e < M_MAX; e++) begin
                        if (M_MAX_W'(e) == idx_q) begin
                            buf_d[e] = buf_q[e] ^ flip_mask;
                        end
                    end
                    if (cnt_q != '1) begin
                        cnt_d = cnt_q + M_MAX_W'(1);
                    end
                end
                idx_d = idx_q + M_MAX_W'(1);
                if (idx_q == m_q - M_MAX_W'(1)) begin
                    state_d = OUT;
                end
            end

            OUT: begin
                // mutant_valid trails entry into OUT by one cycle; the ack is
                // only honoured once the mutant is actually being presented.
                if (valid_q && mutant_ack) begin
                    state_d = IDLE;
                end else begin
                    valid_d = 1'b1;
                end
            end

            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        // NOTE: the chromosome buffer is reset along with the control state
        // because it drives mutant_ary, which must read zero out of reset.
        if (rst_any) begin
            state_q <= IDLE;
            buf_q   <= '0;
            m_q     <= '0;
            rate_q  <= '0;
            idx_q   <= '0;
            cnt_q   <= '0;
            valid_q <= 1'b0;
        end else begin
            // NOTE: non-blocking updates so every register samples the
            // pre-edge values computed above.
            state_q <= state_d;
            buf_q   <= buf_d;
            m_q     <= m_d;
            rate_q  <= rate_d;
            idx_q   <= idx_d;
            cnt_q   <= cnt_d;
            valid_q <= valid_d;
        end
    end

    assign mutant_valid = valid_q;
    assign mutant_ary   = buf_q;
    assign mut_cnt      = cnt_q;

endmodule
